// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the two-requester data-memory arbiter:
//   FSM state encoding, the data word returned on a timeout abort,
//   and the requester ids (also used as grant ids).
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles both requester ports and the single memory data port.
//   Requester i uses slice [i*W +: W] of the packed request vectors.
//   Modports:
//     master - the arbiter: takes requests, drives acks and memory strobes
//     slave  - the environment: requesters plus the memory itself
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BSEL_W = DATA_W / 8;

    logic [1:0]          req_valid;
    logic [1:0]          req_wen;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [2*BSEL_W-1:0] req_bsel;
    logic [1:0]          req_ack;
    logic [DATA_W-1:0]   resp_rdata;

    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ren;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BSEL_W-1:0]   mem_bsel;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_bsel,
        output req_ack, resp_rdata,
        output mem_addr, mem_ren, mem_wen, mem_wdata, mem_bsel,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_bsel,
        input  req_ack, resp_rdata,
        input  mem_addr, mem_ren, mem_wen, mem_wdata, mem_bsel,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/dmem_arbiter_arb_pick2.sv
// arb_pick2
//   Combinational 2-way winner select.
//   Ports: req[1:0] pending requests, last_grant id of the previous winner,
//          grant id of the winner (meaningful only when |req).
//   Build option ARB_ROUND_ROBIN_EN: a tie goes to the requester that did
//   not win last time. Without it, requester 0 (CPU) always wins a tie.
module arb_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = REQ_CPU;
        if (&req)       grant = ~last_grant;
        else if (req[1]) grant = REQ_DMA;
    end
`else
    // Fixed priority has no history; keep the port so both builds share a shell.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = REQ_CPU;
        if (!req[0] && req[1]) grant = REQ_DMA;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Serialises CPU (requester 0) and DMA (requester 1) accesses onto one
//   memory data port: latches the winner's operands, issues a one-cycle
//   read/write strobe, waits for mem_ready (bounded by TIMEOUT), then returns
//   a one-cycle ack with read data.
//   Ports: clk, reset (sync, active high); bus (dmem_arbiter_if.master);
//          busy = FSM not idle; timeout_err = sticky timeout flag.
//   Build option ARB_ROUND_ROBIN_EN selects round-robin tie breaking
//   (inside arb_pick2); default is fixed CPU priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.master bus,
    output logic           busy,
    output logic           timeout_err
);
    localparam int         BSEL_W    = DATA_W / 8;
    // Counter starts at 0 on WAIT entry, so the last allowed WAIT cycle is TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic              gnt;
    logic              winner;
    logic              last_grant;
    logic              is_write;
    logic [7:0]        wait_cnt;
    logic [1:0]        ack;
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BSEL_W-1:0] bsel_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [BSEL_W-1:0] sel_bsel;
    logic              sel_wen;

    arb_pick2 u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (gnt)
    );

    // Operands of whichever requester wins this cycle.
    always_comb begin
        sel_addr  = gnt ? bus.req_addr[ADDR_W +: ADDR_W]  : bus.req_addr[0 +: ADDR_W];
        sel_wdata = gnt ? bus.req_wdata[DATA_W +: DATA_W] : bus.req_wdata[0 +: DATA_W];
        sel_bsel  = gnt ? bus.req_bsel[BSEL_W +: BSEL_W]  : bus.req_bsel[0 +: BSEL_W];
        sel_wen   = gnt ? bus.req_wen[1] : bus.req_wen[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ack         <= '0;
            ren         <= 1'b0;
            wen         <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bsel_q      <= '0;
            rdata_q     <= '0;
            is_write    <= 1'b0;
            winner      <= REQ_CPU;
            last_grant  <= REQ_DMA;
            wait_cnt    <= '0;
        end else begin
            // Strobes and ack are single-cycle pulses.
            ack <= '0;
            ren <= 1'b0;
            wen <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.req_valid) begin
                        winner     <= gnt;
                        last_grant <= gnt;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        bsel_q     <= sel_bsel;
                        is_write   <= sel_wen;
                        ren        <= ~sel_wen;
                        wen        <= sel_wen;
                        busy       <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // mem_ready seen here belongs to nothing we issued; ignore it.
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_ready) begin
                        rdata_q     <= is_write ? '0 : bus.mem_rdata;
                        ack[winner] <= 1'b1;
                        state       <= ST_RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rdata_q     <= DATA_W'(TIMEOUT_DATA);
                        timeout_err <= 1'b1;
                        ack[winner] <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ack    = ack;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_ren    = ren;
    assign bus.mem_wen    = wen;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_bsel   = bsel_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Scoreboard bench for dmem_arbiter: expected {ack, rdata} entries are
//   queued as each request is driven and popped when the ack appears.
//   A small memory model answers strobes after a programmable delay.
//   Handles both tie-break builds (ARB_ROUND_ROBIN_EN defined or not).
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic [1:0]  ack;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic timeout_err;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Read data the memory returns for an address (unless overridden).
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0], 16'h0} ^ a ^ 32'h0F0F_3C3C;
    endfunction

    // ---------------- memory model ----------------
    // rdy_dly: cycles after the strobe cycle until mem_ready (-1 = never).
    int          rdy_dly   = 1;
    int          rdy_cnt   = -1;
    bit          issue_rdy = 1'b0;
    bit          rd_ovr    = 1'b0;
    logic [31:0] rd_val    = '0;
    int          ren_cyc   = 0;
    int          wen_cyc   = 0;
    logic [31:0] st_addr   = '0;
    logic [31:0] st_wdata  = '0;
    logic [3:0]  st_bsel   = '0;

    always @(negedge clk) begin
        bus.mem_ready = 1'b0;
        if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) begin
                bus.mem_ready = 1'b1;
                rdy_cnt = -1;
            end
        end
        if (bus.mem_ren || bus.mem_wen) begin
            if (bus.mem_ren) ren_cyc++;
            if (bus.mem_wen) wen_cyc++;
            st_addr  = bus.mem_addr;
            st_wdata = bus.mem_wdata;
            st_bsel  = bus.mem_bsel;
            rdy_cnt  = rdy_dly;
            if (issue_rdy) bus.mem_ready = 1'b1;
        end
        bus.mem_rdata = rd_ovr ? rd_val : pat(bus.mem_addr);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive_req(input int id, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] bsel);
        bus.req_wen[id]            = wr;
        bus.req_addr[id*AW +: AW]  = addr;
        bus.req_wdata[id*DW +: DW] = wdata;
        bus.req_bsel[id*4 +: 4]    = bsel;
        bus.req_valid[id]          = 1'b1;
    endtask

    // Waits (bounded) for an ack; n counts negedges since the call.
    task automatic await_ack(output logic [1:0] a, output logic [31:0] d,
                             output int n, output bit to);
        a = '0; d = '0; n = 0; to = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n++;
            if (|bus.req_ack) begin
                a  = bus.req_ack;
                d  = bus.resp_rdata;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_terr got=%b want=0", timeout_err); end
        total++; if (bus.req_ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b want=00", bus.req_ack); end
        total++; if ({bus.mem_ren, bus.mem_wen} !== 2'b00) begin bad++; $display("FAIL reset_strobe got=%b want=00", {bus.mem_ren, bus.mem_wen}); end
        total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", bus.mem_addr); end
        total++; if ({bus.mem_wdata, bus.mem_bsel} !== 36'h0) begin bad++; $display("FAIL reset_wdata_bsel got=%h want=0", {bus.mem_wdata, bus.mem_bsel}); end
        total++; if (bus.resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.resp_rdata); end
    endtask

    task automatic test_cpu_read();
        logic [1:0] a; logic [31:0] d; int n; bit to; exp_t e;
        int r0 = ren_cyc, w0 = wen_cyc;
        rdy_dly = 2; rd_ovr = 1'b1; rd_val = 32'h1234_5678;
        exp_q.push_back('{ack: 2'b01, rdata: 32'h1234_5678});
        drive_req(0, 1'b0, 32'h10, 32'h0, 4'hF);
        await_ack(a, d, n, to);
        bus.req_valid[0] = 1'b0;
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL cpu_read_ack_timeout no ack in 40 cycles"); end
        total++; if (a !== e.ack) begin bad++; $display("FAIL cpu_read_ack got=%b want=%b", a, e.ack); end
        total++; if (d !== e.rdata) begin bad++; $display("FAIL cpu_read_rdata got=%h want=%h", d, e.rdata); end
        // IDLE cycle, ISSUE, WAIT x2 -> ack on the 4th edge after the request.
        total++; if (n !== 4) begin bad++; $display("FAIL cpu_read_latency got=%0d want=4", n); end
        total++; if ((ren_cyc - r0) !== 1 || (wen_cyc - w0) !== 0) begin bad++; $display("FAIL cpu_read_strobes ren=%0d wen=%0d want 1/0", ren_cyc - r0, wen_cyc - w0); end
        total++; if (st_addr !== 32'h10) begin bad++; $display("FAIL cpu_read_addr got=%h want=10", st_addr); end
        rd_ovr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dma_write();
        logic [1:0] a; logic [31:0] d; int n; bit to; exp_t e;
        int r0 = ren_cyc, w0 = wen_cyc;
        rdy_dly = 1;
        exp_q.push_back('{ack: 2'b10, rdata: 32'h0});
        drive_req(1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'b0011);
        await_ack(a, d, n, to);
        bus.req_valid[1] = 1'b0;
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL dma_write_ack_timeout no ack in 40 cycles"); end
        total++; if (a !== e.ack) begin bad++; $display("FAIL dma_write_ack got=%b want=%b", a, e.ack); end
        total++; if (d !== e.rdata) begin bad++; $display("FAIL dma_write_rdata got=%h want=%h", d, e.rdata); end
        total++; if (n !== 3) begin bad++; $display("FAIL dma_write_latency got=%0d want=3", n); end
        total++; if ((wen_cyc - w0) !== 1 || (ren_cyc - r0) !== 0) begin bad++; $display("FAIL dma_write_strobes wen=%0d ren=%0d want 1/0", wen_cyc - w0, ren_cyc - r0); end
        total++; if (st_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL dma_write_wdata got=%h want=cafef00d", st_wdata); end
        total++; if (st_bsel !== 4'b0011) begin bad++; $display("FAIL dma_write_bsel got=%b want=0011", st_bsel); end
        total++; if (st_addr !== 32'h20) begin bad++; $display("FAIL dma_write_addr got=%h want=20", st_addr); end
        @(negedge clk);
    endtask

    task automatic test_issue_ready();
        logic [1:0] a; logic [31:0] d; int n; bit to; exp_t e;
        rdy_dly = 3; issue_rdy = 1'b1;
        exp_q.push_back('{ack: 2'b01, rdata: pat(32'h44)});
        drive_req(0, 1'b0, 32'h44, 32'h0, 4'hF);
        await_ack(a, d, n, to);
        bus.req_valid[0] = 1'b0;
        issue_rdy = 1'b0;
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL issue_ready_ack_timeout no ack in 40 cycles"); end
        total++; if (a !== e.ack) begin bad++; $display("FAIL issue_ready_ack got=%b want=%b", a, e.ack); end
        total++; if (d !== e.rdata) begin bad++; $display("FAIL issue_ready_rdata got=%h want=%h", d, e.rdata); end
        // ISSUE-cycle ready ignored; the fresh one 3 cycles after the strobe completes it.
        total++; if (n !== 5) begin bad++; $display("FAIL issue_ready_latency got=%0d want=5", n); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [1:0] a; logic [31:0] d; int n; bit to; exp_t e;
        rdy_dly = -1;
        exp_q.push_back('{ack: 2'b01, rdata: 32'hDEAD_BEEF});
        drive_req(0, 1'b0, 32'h30, 32'h0, 4'hF);
        await_ack(a, d, n, to);
        bus.req_valid[0] = 1'b0;
        e = exp_q.pop_front();
        total++; if (to) begin bad++; $display("FAIL timeout_ack_timeout no ack in 40 cycles"); end
        total++; if (a !== e.ack) begin bad++; $display("FAIL timeout_ack got=%b want=%b", a, e.ack); end
        total++; if (d !== e.rdata) begin bad++; $display("FAIL timeout_rdata got=%h want=%h", d, e.rdata); end
        // ISSUE + 8 WAIT cycles, ack on the 10th edge.
        total++; if (n !== 10) begin bad++; $display("FAIL timeout_latency got=%0d want=10", n); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_set got=%b want=1", timeout_err); end
        @(negedge clk);
        // A later good access must leave the flag set.
        rdy_dly = 1;
        exp_q.push_back('{ack: 2'b10, rdata: pat(32'h40)});
        drive_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
        await_ack(a, d, n, to);
        bus.req_valid[1] = 1'b0;
        e = exp_q.pop_front();
        total++; if (to || a !== e.ack || d !== e.rdata) begin bad++; $display("FAIL timeout_followup got ack=%b rdata=%h want ack=%b rdata=%h", a, d, e.ack, e.rdata); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b want=1", timeout_err); end
        @(negedge clk);
    endtask

    task automatic test_reset_wait();
        logic [1:0] a; logic [31:0] d; int n; bit to; exp_t e;
        int r0, w0; bit seen_ack;
        rdy_dly = -1;
        drive_req(0, 1'b0, 32'h50, 32'h0, 4'hF);
        repeat (3) @(negedge clk);           // now in WAIT
        reset = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_wait_busy got=%b want=0", busy); end
        total++; if (bus.req_ack !== 2'b00) begin bad++; $display("FAIL rst_wait_ack got=%b want=00", bus.req_ack); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_wait_terr got=%b want=0", timeout_err); end
        r0 = ren_cyc; w0 = wen_cyc; seen_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (|bus.req_ack) seen_ack = 1'b1;
        end
        total++; if (seen_ack || ren_cyc !== r0 || wen_cyc !== w0) begin bad++; $display("FAIL rst_wait_quiet ack=%b strobes=%0d want 0/0", seen_ack, (ren_cyc - r0) + (wen_cyc - w0)); end
        rdy_dly = 1;
        exp_q.push_back('{ack: 2'b01, rdata: pat(32'h58)});
        drive_req(0, 1'b0, 32'h58, 32'h0, 4'hF);
        await_ack(a, d, n, to);
        bus.req_valid[0] = 1'b0;
        e = exp_q.pop_front();
        total++; if (to || a !== e.ack || d !== e.rdata) begin bad++; $display("FAIL rst_wait_next got ack=%b rdata=%h want ack=%b rdata=%h", a, d, e.ack, e.rdata); end
        total++; if (n !== 3) begin bad++; $display("FAIL rst_wait_next_latency got=%0d want=3", n); end
        @(negedge clk);
    endtask

    task automatic test_tie();
        logic [1:0] a; logic [31:0] d; int n; bit to; exp_t e;
        apply_reset();                       // last_grant back to DMA
        rdy_dly = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (k % 2 == 0) exp_q.push_back('{ack: 2'b01, rdata: pat(32'h100)});
            else            exp_q.push_back('{ack: 2'b10, rdata: pat(32'h200)});
`else
            exp_q.push_back('{ack: 2'b01, rdata: pat(32'h100)});
`endif
        end
        drive_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
        drive_req(1, 1'b0, 32'h200, 32'h0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            await_ack(a, d, n, to);
            if (k == 3) bus.req_valid = '0;
            e = exp_q.pop_front();
            total++; if (to || a !== e.ack) begin bad++; $display("FAIL tie_grant_%0d got=%b want=%b", k, a, e.ack); end
            total++; if (d !== e.rdata) begin bad++; $display("FAIL tie_rdata_%0d got=%h want=%h", k, d, e.rdata); end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_wen   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_bsel  = '0;
        apply_reset();
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_issue_ready();
        test_timeout();
        test_reset_wait();
        test_tie();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
